// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory unit.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int CNT_W    = 4;
  localparam int WORD_OFF = 3;

endpackage

// File: rtl/dmem_if.sv
// Processor-side load/store bus of the data memory unit.
interface dmem_if;

  logic [63:0] Address;
  logic [63:0] WriteData;
  logic        MemoryRead;
  logic        MemoryWrite;
  logic [63:0] ReadData;
  logic        Busy;
  logic        Done;
  logic        Fault;

  modport master (
    output Address, WriteData, MemoryRead, MemoryWrite,
    input  ReadData, Busy, Done, Fault
  );

  modport slave (
    input  Address, WriteData, MemoryRead, MemoryWrite,
    output ReadData, Busy, Done, Fault
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 64 storage: one write port, one synchronous read port.
// The read register holds its value until the next read and clears on reset; contents do not.
module dmem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          Clk,
  input  logic          ResetL,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH_WORDS];
  logic [63:0] rdata_q;

  always_ff @(posedge Clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge Clk) begin
    if (!ResetL)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_unit.sv
// Multi-cycle data memory with fixed access latency, Busy/Done/Fault handshake.
// Optional DMEM_ALIGN_CHECK_EN: misaligned requests are rejected with Fault.
module data_memory_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input logic  Clk,
  input logic  ResetL,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [AW-1:0]      idx_q;
  logic [63:0]        wdata_q;
  logic               is_wr_q;
  logic               busy_q, done_q, fault_q;

  logic req_one, req_both, misaligned, idle, accept, reject, enter_resp;
  logic acc_wr;
  logic [AW-1:0] acc_idx;
  logic [63:0]   acc_data;
  logic [63:0]   rdata;

  assign req_one  = bus.MemoryRead ^ bus.MemoryWrite;
  assign req_both = bus.MemoryRead & bus.MemoryWrite;
`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = |bus.Address[WORD_OFF-1:0];
`else
  assign misaligned = 1'b0;
`endif
  assign idle   = (state_q == IDLE);
  assign accept = idle && req_one && !misaligned;
  assign reject = idle && (req_both || (req_one && misaligned));

  // With zero latency the array access happens on the capture edge itself,
  // so the live bus is used instead of the captured copies.
  assign enter_resp = (accept && (LATENCY == 0)) || (state_q == WAIT && cnt_q == '0);
  assign acc_wr     = idle ? bus.MemoryWrite : is_wr_q;
  assign acc_idx    = idle ? bus.Address[WORD_OFF +: AW] : idx_q;
  assign acc_data   = idle ? bus.WriteData : wdata_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .Clk     (Clk),
    .ResetL  (ResetL),
    .we_i    (ResetL && enter_resp && acc_wr),
    .waddr_i (acc_idx),
    .wdata_i (acc_data),
    .re_i    (ResetL && enter_resp && !acc_wr),
    .raddr_i (acc_idx),
    .rdata_o (rdata)
  );

  always_ff @(posedge Clk) begin
    if (!ResetL) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q   <= acc_idx;
            wdata_q <= bus.WriteData;
            is_wr_q <= bus.MemoryWrite;
            busy_q  <= 1'b1;
            if (LATENCY > 0) begin
              state_q <= WAIT;
              cnt_q   <= LAT_M1;
            end else begin
              state_q <= RESP;
              done_q  <= 1'b1;
            end
          end else if (reject) begin
            fault_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ReadData = rdata;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Fault    = fault_q;

  logic unused_addr;
  assign unused_addr = ^{bus.Address[63:WORD_OFF+AW], bus.Address[WORD_OFF-1:0]};

endmodule

// File: doc/data_memory_unit.md
DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

Interface
REQ-001 The unit SHALL expose parameter DEPTH_WORDS, default 64, meaning the number of 64-bit storage words (power of two, 2..1024).
REQ-002 The unit SHALL expose parameter LATENCY, default 2, meaning wait cycles between request capture and completion (0..15).
REQ-003 The unit SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The unit SHALL have port ResetL, input, 1 bit: reset, synchronous, active-low.
REQ-005 The unit SHALL have port Address, input, 64 bits: byte address, driven by ALU result BusW.
REQ-006 The unit SHALL have port WriteData, input, 64 bits: store data.
REQ-007 The unit SHALL have port MemoryRead, input, 1 bit: load request.
REQ-008 The unit SHALL have port MemoryWrite, input, 1 bit: store request.
REQ-009 The unit SHALL have port ReadData, output, 64 bits: load result.
REQ-010 The unit SHALL have port Busy, output, 1 bit: access in progress, processor stalls.
REQ-011 The unit SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-012 The unit SHALL have port Fault, output, 1 bit: one-cycle rejected-request pulse.

Function
REQ-013 The unit SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 In IDLE, the unit SHALL capture Address, WriteData and request type at the edge where exactly one of MemoryRead/MemoryWrite is high.
REQ-015 After capture, the unit SHALL go to WAIT with counter=LATENCY-1 if LATENCY>0, else directly to RESP.
REQ-016 In WAIT, the counter SHALL decrement each cycle; at counter 0 the unit SHALL go to RESP on the next edge.
REQ-017 Done SHALL be high for exactly the one cycle spent in RESP (cycle N+1+LATENCY for capture edge N); the unit SHALL then return to IDLE.
REQ-018 A store SHALL update the array at the edge entering RESP; a load SHALL register ReadData at the same edge.
REQ-019 ReadData SHALL hold its last load value through stores, idle cycles and faults.
REQ-020 Word index SHALL be Address[3+log2(DEPTH_WORDS)-1:3]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*8.
REQ-021 Busy SHALL be high in WAIT and RESP, low in IDLE.
REQ-022 Requests present while Busy SHALL be ignored, never queued.
REQ-023 MemoryRead and MemoryWrite both high in IDLE SHALL produce a Fault pulse the next cycle; no access, state stays IDLE.
REQ-024 Back-to-back: a request present in the cycle after RESP (IDLE) SHALL be captured normally, giving one idle cycle between accesses.

Reset
REQ-025 With ResetL low at an edge, the unit SHALL set state IDLE, counter 0, ReadData 0, Busy 0, Done 0, Fault 0.
REQ-026 Reset mid-access SHALL abort the access; a pending store SHALL NOT modify the array.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN defined: Address[2:0]!=0 on a request in IDLE SHALL produce Fault the next cycle, no access, state stays IDLE.
REQ-029 Macro DMEM_ALIGN_CHECK_EN undefined: Address[2:0] SHALL be ignored and misaligned requests proceed as aligned.

Structure
REQ-030 Package dmem_pkg SHALL hold the FSM state enum, the counter width constant (4) and the word-offset constant (3).
REQ-031 Storage SHALL be a sub-module dmem_array: one write port plus one synchronous read port, DEPTH_WORDS x 64.

Verification
REQ-032 Store 0x0123_4567_89AB_CDEF @0x10, then load @0x10, LATENCY=2 -> Done 3 cycles after each capture, ReadData=0x0123456789ABCDEF, Busy high 3 cycles per access.
REQ-033 LATENCY=0: load @0x0 after reset -> Done next cycle, ReadData=0, Busy high exactly 1 cycle.
REQ-034 DEPTH_WORDS=64: store 0xAA @0x200, load @0x0 -> ReadData=0xAA (wrap).
REQ-035 MemoryRead=MemoryWrite=1 -> Fault 1 cycle, Done never, Busy stays 0; store @0x9 with macro -> Fault and array unchanged; without macro -> word 1 written.
REQ-036 Store 0xFF @0x8, ResetL low in WAIT cycle -> all outputs 0 next cycle; later load @0x8 returns prior value, not 0xFF.
